// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the instruction memory address,
// buffers fetched words in a 2-entry FIFO and hands them to decode over valid/ready.
module fetch_sequencer #(
   parameter int            AW       = 8,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [31:0]   IMA,
   input  logic [31:0]   IMRD,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic [31:0]   instr_out,
   output logic [AW-1:0] pc_out,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic          halted
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [1:0]    cnt_q, cnt_d;

   // buffer slots: slot 0 is always the head
   logic [AW-1:0] pc0_q, pc1_q;
   logic [31:0]   ins0_q, ins1_q;

   logic fill, pop, fetch, push;

   assign fill  = (IMRD == 32'hFFFF_FFFF);
   // a redirect cycle is never a transfer, even with instr_ready high
   assign pop   = (cnt_q != 2'd0) && instr_ready && !redirect_valid;
   assign fetch = (state_q == RUN) && !redirect_valid && ((cnt_q != 2'd2) || pop);
   assign push  = fetch && !fill;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      if (redirect_valid) begin
         state_d = RUN;
         pc_d    = redirect_pc;
         cnt_d   = 2'd0;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (fetch && fill) state_d = HALT;
            default: ;
         endcase
         if (push) pc_d = pc_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Payload needs no reset: outputs are masked by the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         if (pop) begin
            if (cnt_q == 2'd2) begin
               pc0_q  <= pc1_q;
               ins0_q <= ins1_q;
               pc1_q  <= pc_q;
               ins1_q <= IMRD;
            end else begin
               pc0_q  <= pc_q;
               ins0_q <= IMRD;
            end
         end else if (cnt_q == 2'd0) begin
            pc0_q  <= pc_q;
            ins0_q <= IMRD;
         end else begin
            pc1_q  <= pc_q;
            ins1_q <= IMRD;
         end
      end else if (pop) begin
         pc0_q  <= pc1_q;
         ins0_q <= ins1_q;
      end
   end

   assign IMA         = {{(32-AW){1'b0}}, pc_q};
   assign instr_valid = (cnt_q != 2'd0);
   assign instr_out   = instr_valid ? ins0_q : 32'd0;
   assign pc_out      = instr_valid ? pc0_q : '0;
   assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a queue-based reference model.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        redirect_valid = 1'b0;
   logic        instr_ready = 1'b0;
   logic [7:0]  redirect_pc = 8'd0;
   logic [31:0] IMA, IMRD, instr_out;
   logic [7:0]  pc_out;
   logic        instr_valid, halted;

   logic [31:0] mem [256];
   assign IMRD = mem[IMA[7:0]];

   fetch_sequencer #(.AW(8), .RESET_PC(8'd0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .IMA(IMA), .IMRD(IMRD),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .halted(halted)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct { int pc; logic [31:0] w; } ent_t;
   ent_t q[$];
   int   m_pc;
   int   m_st;   // 0 idle, 1 run, 2 halt

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc = 0;
      m_st = 0;
   endtask

   task automatic compare_all();
      logic        ev;
      logic [31:0] ew;
      int          ep;
      ev = (q.size() > 0);
      ew = ev ? q[0].w : 32'd0;
      ep = ev ? q[0].pc : 0;
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, ev});
      chk("instr_out", instr_out, ew);
      chk("pc_out", {24'd0, pc_out}, ep);
      chk("halted", {31'd0, halted}, (m_st == 2) ? 32'd1 : 32'd0);
      chk("IMA", IMA, m_pc);
   endtask

   // one rising edge of the specified behaviour, using the inputs held across it
   task automatic model_step();
      bit          pop, fetch;
      logic [31:0] w;
      pop = (q.size() > 0) && instr_ready;
      if (redirect_valid) begin
         m_pc = redirect_pc;
         q.delete();
         m_st = 1;
      end else begin
         fetch = (m_st == 1) && (q.size() < 2 || pop);
         if (pop) void'(q.pop_front());
         if (fetch) begin
            w = mem[m_pc];
            if (w == 32'hFFFF_FFFF) m_st = 2;
            else begin
               q.push_back('{pc: m_pc, w: w});
               m_pc = (m_pc + 1) % 256;
            end
         end
         if (m_st == 0 && start) m_st = 1;
      end
   endtask

   task automatic cycle(input bit s, input bit r, input bit rv, input int rpc);
      @(negedge clk);
      start          = s;
      instr_ready    = r;
      redirect_valid = rv;
      redirect_pc    = rpc[7:0];
      #1 compare_all();
      @(posedge clk);
      if (rst_n) model_step();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2;
      start = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'd0;
      rst_n = 1'b0;
      model_reset();
      #1 compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom() & 32'h7FFF_FFFF;
      mem[0] = 32'h20020005; mem[1] = 32'h2003000c;
      mem[2] = 32'h2067fff7; mem[3] = 32'h00e22025;
      mem[13] = 32'hFFFF_FFFF;
      model_reset();

      #1 compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // start, stream to the fill word at 13, drain
      cycle(1, 1, 0, 0);
      for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 0);
      // redirect out of HALT, then backpressure and release
      cycle(0, 1, 1, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
      // buffer holds pc 5,6 when a redirect to 2 arrives with ready high
      cycle(0, 0, 1, 5);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
      cycle(0, 1, 1, 2);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
      // wrap past 255
      cycle(0, 1, 1, 255);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
      // reset mid-run, then redirect out of IDLE
      apply_reset();
      cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 20);
      for (int i = 0; i < 4; i++) cycle(0, $urandom_range(0, 1), 0, 0);

      // randomized phase with sprinkled fill words
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : ($urandom() & 32'h7FFF_FFFF);
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 499) apply_reset();
         else cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 24) == 0, $urandom_range(0, 255));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
